// File: rtl/aq_axis_fifo_rd_stream.sv
// Read-side stream stage of the async AXIS FIFO: turns the registered FIFO read port into a
// back-pressured AXI-Stream master with length-driven TLAST. Optional packet counter: AQ_AXIS_FIFO_RD_PKT_CNT_EN.
module aq_axis_fifo_rd_stream #(
  parameter int FIFO_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  RST_N,
  output logic                  FIFO_RD_ENA,
  input  logic [FIFO_WIDTH-1:0] FIFO_RD_DATA,
  input  logic                  FIFO_RD_EMPTY,
  input  logic [LEN_WIDTH-1:0]  PKT_LEN_M1,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [FIFO_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic                  BUSY
`ifdef AQ_AXIS_FIFO_RD_PKT_CNT_EN
  ,
  output logic [31:0]           PKT_COUNT,
  input  logic                  PKT_COUNT_CLR
`endif
);

  logic                  run_q;
  logic                  inflight_q;
  logic [1:0]            cnt_q, cnt_d;
  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] tail_q, tail_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  len_cur;
  logic [1:0]            occ;
  logic                  pop;
  logic                  last;

  assign occ  = cnt_q + {1'b0, inflight_q};
  assign pop  = (cnt_q != 2'd0) & M_AXIS_TREADY;

  // run_q gives a synchronous release: no read is issued until one full edge after RST_N rises.
  assign FIFO_RD_ENA = run_q & ~FIFO_RD_EMPTY & ((occ < 2'd2) | pop);

  assign M_AXIS_TVALID = (cnt_q != 2'd0);
  assign M_AXIS_TDATA  = head_q;

  // Length is sampled live on the first beat and frozen afterwards in len_q.
  assign len_cur      = (beat_q == '0) ? PKT_LEN_M1 : len_q;
  assign last         = (beat_q == len_cur);
  assign M_AXIS_TLAST = M_AXIS_TVALID & last;

  assign BUSY = (cnt_q != 2'd0) | inflight_q | (beat_q != '0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({inflight_q, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = FIFO_RD_DATA;
          cnt_d  = 2'd1;
        end else begin
          tail_d = FIFO_RD_DATA;
          cnt_d  = 2'd2;
        end
      end
      2'b01: begin
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy never exceeds 2, so a capture with pop only happens at 1 or 2 entries.
        if (cnt_q == 2'd1) begin
          head_d = FIFO_RD_DATA;
        end else begin
          head_d = tail_q;
          tail_d = FIFO_RD_DATA;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    beat_d = beat_q;
    len_d  = len_q;
    if (pop) begin
      if (beat_q == '0) len_d = PKT_LEN_M1;
      beat_d = last ? '0 : beat_q + LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge ACLK or negedge RST_N) begin
    if (!RST_N) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      beat_q     <= '0;
      len_q      <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= FIFO_RD_ENA;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
    end
  end

`ifdef AQ_AXIS_FIFO_RD_PKT_CNT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (PKT_COUNT_CLR)           pkt_cnt_d = '0;
    else if (pop && last)        pkt_cnt_d = pkt_cnt_q + 32'd1;
  end

  always_ff @(posedge ACLK or negedge RST_N) begin
    if (!RST_N) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end

  assign PKT_COUNT = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_aq_axis_fifo_rd_stream.sv
// Scoreboard bench for aq_axis_fifo_rd_stream: directed words go into a FIFO model and an
// expected queue; a negedge monitor pops and compares every handshake plus protocol properties.
module tb_aq_axis_fifo_rd_stream;
  localparam int FW = 32;
  localparam int LW = 16;

  logic          ACLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          FIFO_RD_ENA;
  logic [FW-1:0] FIFO_RD_DATA = '0;
  logic          FIFO_RD_EMPTY;
  logic [LW-1:0] PKT_LEN_M1 = '0;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TREADY = 1'b0;
  logic [FW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TLAST;
  logic          BUSY;
`ifdef AQ_AXIS_FIFO_RD_PKT_CNT_EN
  logic [31:0]   PKT_COUNT;
  logic          PKT_COUNT_CLR = 1'b0;
`endif

  always #5 ACLK = ~ACLK;

  aq_axis_fifo_rd_stream #(.FIFO_WIDTH(FW), .LEN_WIDTH(LW)) dut (
    .ACLK(ACLK), .RST_N(RST_N),
    .FIFO_RD_ENA(FIFO_RD_ENA), .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_RD_EMPTY(FIFO_RD_EMPTY),
    .PKT_LEN_M1(PKT_LEN_M1),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST),
    .BUSY(BUSY)
`ifdef AQ_AXIS_FIFO_RD_PKT_CNT_EN
    , .PKT_COUNT(PKT_COUNT), .PKT_COUNT_CLR(PKT_COUNT_CLR)
`endif
  );

  // Upstream FIFO model with a registered read (data valid the cycle after FIFO_RD_ENA).
  logic [FW-1:0] fmem [0:255];
  logic [7:0]    f_wp = 8'd0;
  logic [7:0]    f_rp = 8'd0;
  assign FIFO_RD_EMPTY = (f_wp == f_rp);
  always @(posedge ACLK) begin
    if (FIFO_RD_ENA) begin
      FIFO_RD_DATA <= fmem[f_rp];
      f_rp         <= f_rp + 8'd1;
    end
  end

  // Expected-beat queue: stimulus pushes, monitor pops.
  logic [FW-1:0] exp_d [0:255];
  logic          exp_l [0:255];
  int            exp_wp = 0;
  int            exp_rp = 0;

  logic          rel_chk = 1'b0, nb_chk = 1'b0, busy_chk = 1'b0, pc_chk = 1'b0, end_req = 1'b0;
  logic [31:0]   pc_exp = '0;
  int            tmo_cnt = 0;
  int            vecs = 0, errs = 0;
  int            rel = 0;

  always @(posedge ACLK or negedge RST_N) begin
    if (!RST_N) rel <= 0;
    else        rel <= rel + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
    end
  endtask

  initial begin : monitor
    logic          pv_stall;
    logic [FW-1:0] pv_d;
    logic          pv_l;
    logic          end_done;
    int            outst;
    pv_stall = 1'b0; pv_d = '0; pv_l = 1'b0; end_done = 1'b0; outst = 0;
    forever begin
      @(negedge ACLK);
      if (!RST_N) begin
        chk("rst_rd_ena", FIFO_RD_ENA, 0);
        chk("rst_tvalid", M_AXIS_TVALID, 0);
        chk("rst_tdata",  M_AXIS_TDATA, 0);
        chk("rst_tlast",  M_AXIS_TLAST, 0);
        chk("rst_busy",   BUSY, 0);
`ifdef AQ_AXIS_FIFO_RD_PKT_CNT_EN
        chk("rst_pkt_count", PKT_COUNT, 0);
`endif
        pv_stall = 1'b0;
        outst    = 0;
      end else begin
        if (FIFO_RD_EMPTY) chk("rd_while_empty", FIFO_RD_ENA, 0);
        if (pv_stall) begin
          chk("stall_tvalid", M_AXIS_TVALID, 1);
          chk("stall_tdata",  M_AXIS_TDATA, pv_d);
          chk("stall_tlast",  M_AXIS_TLAST, pv_l);
        end
        if (rel_chk && rel >= 1 && rel <= 3) chk("release_latency", M_AXIS_TVALID, (rel == 3));
        if (nb_chk)   chk("no_bubble", M_AXIS_TVALID, 1);
        if (busy_chk) chk("busy_in_gap", BUSY, 1);
`ifdef AQ_AXIS_FIFO_RD_PKT_CNT_EN
        if (pc_chk)   chk("pkt_count", PKT_COUNT, pc_exp);
`endif
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          if (exp_rp >= exp_wp) begin
            chk("unexpected_beat", M_AXIS_TDATA, 64'hdead);
          end else begin
            chk("tdata", M_AXIS_TDATA, exp_d[exp_rp]);
            chk("tlast", M_AXIS_TLAST, exp_l[exp_rp]);
            exp_rp++;
          end
        end
        outst = outst + int'(FIFO_RD_ENA) - int'(M_AXIS_TVALID && M_AXIS_TREADY);
        if (outst > 2) chk("occupancy", outst, 2);
        pv_stall = M_AXIS_TVALID & ~M_AXIS_TREADY;
        pv_d     = M_AXIS_TDATA;
        pv_l     = M_AXIS_TLAST;
      end
      if (end_req && !end_done) begin
        chk("all_beats_seen", exp_rp, exp_wp);
        chk("timeouts", tmo_cnt, 0);
        end_done = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic put(input logic [FW-1:0] d, input logic l);
    fmem[f_wp]    = d;
    exp_d[exp_wp] = d;
    exp_l[exp_wp] = l;
    exp_wp++;
    f_wp = f_wp + 8'd1;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_rp < exp_wp && k < budget) begin cyc(); k++; end
    if (k >= budget) tmo_cnt++;
    repeat (3) cyc();
  endtask

  task automatic wait_tv(input int budget);
    int k;
    k = 0;
    while (!M_AXIS_TVALID && k < budget) begin cyc(); k++; end
    if (k >= budget) tmo_cnt++;
  endtask

  initial begin : stim
    int k;
    // Reset with 3 words already queued; 3-beat packet.
    PKT_LEN_M1    = 16'd2;
    M_AXIS_TREADY = 1'b1;
    cyc();
    put(32'hA0, 1'b0); put(32'hA1, 1'b0); put(32'hA2, 1'b1);
    repeat (5) cyc();
    rel_chk = 1'b1;
    RST_N   = 1'b1;
    wait_drain(50);
    rel_chk = 1'b0;

    // 16 words, 4-beat packets, full throughput.
    PKT_LEN_M1 = 16'd3;
    for (int i = 0; i < 16; i++) put(32'(i), (i % 4) == 3);
    wait_tv(20);
    nb_chk = 1'b1;
    repeat (16) cyc();
    nb_chk = 1'b0;
    wait_drain(50);

    // Same data under irregular back-pressure.
    for (int i = 0; i < 16; i++) put(32'(i), (i % 4) == 3);
    k = 0;
    while (exp_rp < exp_wp && k < 400) begin
      M_AXIS_TREADY = (k < 4) ? (k == 0 || k == 3) : 1'($urandom_range(0, 1));
      cyc();
      k++;
    end
    if (k >= 400) tmo_cnt++;
    M_AXIS_TREADY = 1'b1;
    wait_drain(20);

    // Single-beat packets.
    PKT_LEN_M1 = 16'd0;
    for (int i = 0; i < 4; i++) put(32'h100 + 32'(i), 1'b1);
    wait_drain(50);

    // Length changes from 4 to 2 after beat 1 of a packet.
    PKT_LEN_M1    = 16'd3;
    M_AXIS_TREADY = 1'b0;
    put(32'h200, 1'b0); put(32'h201, 1'b0); put(32'h202, 1'b0); put(32'h203, 1'b1);
    put(32'h204, 1'b0); put(32'h205, 1'b1); put(32'h206, 1'b0); put(32'h207, 1'b1);
    wait_tv(20);
    M_AXIS_TREADY = 1'b1;
    cyc(); cyc();
    M_AXIS_TREADY = 1'b0;
    PKT_LEN_M1    = 16'd1;
    cyc();
    M_AXIS_TREADY = 1'b1;
    wait_drain(50);

    // FIFO runs dry mid-packet; BUSY must hold through the gap.
    PKT_LEN_M1 = 16'd3;
    put(32'h300, 1'b0); put(32'h301, 1'b0);
    wait_drain(50);
    busy_chk = 1'b1;
    repeat (10) cyc();
    busy_chk = 1'b0;
    put(32'h302, 1'b0); put(32'h303, 1'b1);
    wait_drain(50);

    // Reset mid-packet: the partial packet is abandoned, the next beat starts fresh.
    put(32'h400, 1'b0); put(32'h401, 1'b0);
    wait_drain(50);
    RST_N = 1'b0;
    repeat (3) cyc();
    RST_N = 1'b1;
    put(32'h410, 1'b0); put(32'h411, 1'b0); put(32'h412, 1'b0); put(32'h413, 1'b1);
    wait_drain(50);

`ifdef AQ_AXIS_FIFO_RD_PKT_CNT_EN
    PKT_COUNT_CLR = 1'b1;
    cyc();
    PKT_COUNT_CLR = 1'b0;
    PKT_LEN_M1    = 16'd0;
    for (int i = 0; i < 5; i++) put(32'h500 + 32'(i), 1'b1);
    wait_drain(50);
    pc_exp = 32'd5;
    pc_chk = 1'b1;
    cyc();
    pc_chk = 1'b0;
    // Clear coincident with a TLAST handshake wins over the increment.
    put(32'h510, 1'b1);
    wait_tv(20);
    PKT_COUNT_CLR = 1'b1;
    cyc();
    PKT_COUNT_CLR = 1'b0;
    pc_exp = 32'd0;
    pc_chk = 1'b1;
    cyc();
    pc_chk = 1'b0;
    wait_drain(20);
`endif

    end_req = 1'b1;
    cyc(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
